reg_file: RTL and testbench

Architectural register file at the receiving end of the write-back stage's dual write port. It holds 16 general registers: R0–R14, plus R15 as the program counter. It accepts up to two register writes per cycle, resolving wr1/wr2 priority, and auto-advances R15 when no write targets it. It serves three combinational read ports (Rn, Rm, Rs) to decode/execute.

---
 rtl/reg_file_if.sv | 39 +++
 rtl/reg_file.sv | 93 +++++++++
 tb/tb_reg_file.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Write-back / read-port bundle for the architectural register file.
// master = pipeline side (writes, read addresses); slave = reg_file.
interface reg_file_if #(
  parameter int DATA_W = 16
);
  logic              wr1;
  logic [3:0]        wr_reg1;
  logic [DATA_W-1:0] wr_data1;
  logic              wr2;
  logic [3:0]        wr_reg2;
  logic [DATA_W-1:0] wr_data2;
  logic              pc_en;
  logic [3:0]        rd_addr_a;
  logic [3:0]        rd_addr_b;
  logic [3:0]        rd_addr_c;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] pc_out;
  logic              wr_collide;

  modport master (
    output wr1, wr_reg1, wr_data1,
    output wr2, wr_reg2, wr_data2,
    output pc_en,
    output rd_addr_a, rd_addr_b, rd_addr_c,
    input  rd_data_a, rd_data_b, rd_data_c,
    input  pc_out, wr_collide
  );

  modport slave (
    input  wr1, wr_reg1, wr_data1,
    input  wr2, wr_reg2, wr_data2,
    input  pc_en,
    input  rd_addr_a, rd_addr_b, rd_addr_c,
    output rd_data_a, rd_data_b, rd_data_c,
    output pc_out, wr_collide
  );
endinterface

// File: rtl/reg_file.sv
// 16-entry register file (R15 = PC) with dual write port and three read ports.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic     clk,
  input  logic     reset,
  reg_file_if.slave rf
);
  localparam int NUM_REGS = 16;
  localparam int NUM_RD   = 3;
  localparam int PC_IDX   = 15;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_collide;

  logic [NUM_REGS-1:0] w_hit1;
  logic [NUM_REGS-1:0] w_hit2;
  logic                w_same_dst;
  logic [3:0]          w_rd_addr [NUM_RD];
  logic [DATA_W-1:0]   w_rd_data [NUM_RD];

  // Per-register write decode; an idle port never matches, so X address/data are harmless.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign w_hit1[gi] = rf.wr1 && (rf.wr_reg1 == 4'(gi));
      assign w_hit2[gi] = rf.wr2 && (rf.wr_reg2 == 4'(gi));
    end
  endgenerate

  assign w_same_dst = rf.wr1 && rf.wr2 && (rf.wr_reg1 == rf.wr_reg2);

  // General registers: port 1 overrides port 2 on a shared destination.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PC_IDX; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else if (w_hit1[i]) begin
        r_regs[i] <= rf.wr_data1;
      end else if (w_hit2[i]) begin
        r_regs[i] <= rf.wr_data2;
      end
    end
  end

  // Program counter: explicit writes beat the auto-increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs[PC_IDX] <= PC_RESET;
    end else if (w_hit1[PC_IDX]) begin
      r_regs[PC_IDX] <= rf.wr_data1;
    end else if (w_hit2[PC_IDX]) begin
      r_regs[PC_IDX] <= rf.wr_data2;
    end else if (rf.pc_en) begin
      r_regs[PC_IDX] <= r_regs[PC_IDX] + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_collide <= 1'b0;
    end else begin
      r_collide <= w_same_dst;
    end
  end

  assign w_rd_addr[0] = rf.rd_addr_a;
  assign w_rd_addr[1] = rf.rd_addr_b;
  assign w_rd_addr[2] = rf.rd_addr_c;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      logic w_fwd1;
      logic w_fwd2;
      assign w_fwd1 = !reset && rf.wr1 && (rf.wr_reg1 == w_rd_addr[gi]);
      assign w_fwd2 = !reset && rf.wr2 && (rf.wr_reg2 == w_rd_addr[gi]);
      assign w_rd_data[gi] = w_fwd1 ? rf.wr_data1 :
                             w_fwd2 ? rf.wr_data2 :
                             r_regs[w_rd_addr[gi]];
`else
      assign w_rd_data[gi] = r_regs[w_rd_addr[gi]];
`endif
    end
  endgenerate

  assign rf.rd_data_a  = w_rd_data[0];
  assign rf.rd_data_b  = w_rd_data[1];
  assign rf.rd_data_c  = w_rd_data[2];
  assign rf.pc_out     = r_regs[PC_IDX];
  assign rf.wr_collide = r_collide;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: array model checked every cycle plus literal expectations.
module tb_reg_file;
  localparam int                DATA_W   = 16;
  localparam logic [DATA_W-1:0] PC_RESET = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(DATA_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .PC_RESET(PC_RESET)) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Architectural model: plain array updated once per clock edge.
  logic [15:0] m_regs [16];
  logic [15:0] m_nxt  [16];
  logic        m_coll  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_pc_written;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [3:0] addr);
`ifdef REGFILE_BYPASS_EN
    if (!reset && bus.wr1 === 1'b1 && bus.wr_reg1 == addr) return bus.wr_data1;
    if (!reset && bus.wr2 === 1'b1 && bus.wr_reg2 == addr) return bus.wr_data2;
`endif
    return m_regs[addr];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 16'h0000;
      m_regs[15] = PC_RESET;
      m_coll     = 1'b0;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      m_nxt        = m_regs;
      m_pc_written = 1'b0;
      m_coll       = bus.wr1 && bus.wr2 && (bus.wr_reg1 == bus.wr_reg2);
      if (bus.wr2) begin
        m_nxt[bus.wr_reg2] = bus.wr_data2;
        if (bus.wr_reg2 == 4'd15) m_pc_written = 1'b1;
      end
      if (bus.wr1) begin
        m_nxt[bus.wr_reg1] = bus.wr_data1;
        if (bus.wr_reg1 == 4'd15) m_pc_written = 1'b1;
      end
      if (!m_pc_written && bus.pc_en) m_nxt[15] = m_regs[15] + 16'd1;
      m_regs = m_nxt;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  logic run_chk = 1'b1;
  always @(negedge clk) begin
    if (m_valid && run_chk) begin
      chk("rd_a",    bus.rd_data_a, exp_read(bus.rd_addr_a));
      chk("rd_b",    bus.rd_data_b, exp_read(bus.rd_addr_b));
      chk("rd_c",    bus.rd_data_c, exp_read(bus.rd_addr_c));
      chk("pc_out",  bus.pc_out,    m_regs[15]);
      chk("collide", {15'd0, bus.wr_collide}, {15'd0, m_coll});
    end
  end

  task automatic drive(input logic rst,
                       input logic w1, input logic [3:0] r1, input logic [15:0] d1,
                       input logic w2, input logic [3:0] r2, input logic [15:0] d2,
                       input logic pe,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    reset        = rst;
    bus.wr1      = w1;
    bus.wr_reg1  = r1;
    bus.wr_data1 = d1;
    bus.wr2      = w2;
    bus.wr_reg2  = r2;
    bus.wr_data2 = d2;
    bus.pc_en    = pe;
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    bus.rd_addr_c = c;
  endtask

  task automatic idle(input logic pe, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, pe, a, b, c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset discards a concurrent write and pc_en.
    drive(1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd15, 4'd0);
    tick();
    idle(1'b0, 4'd3, 4'd15, 4'd0);
    #1;
    chk("reset_r3",  bus.rd_data_a, 16'h0000);
    chk("reset_r15", bus.rd_data_b, 16'h0000);
    chk("reset_pc",  bus.pc_out,    16'h0000);
    chk("reset_col", {15'd0, bus.wr_collide}, 16'h0000);

    // PC preload and wrap.
    drive(1'b0, 1'b1, 4'd15, 16'hFFFE, 1'b0, 4'd0, 16'h0, 1'b0, 4'd15, 4'd0, 4'd1);
    tick();
    idle(1'b1, 4'd15, 4'd0, 4'd1);
    #1;
    chk("pc_load", bus.pc_out, 16'hFFFE);
    tick(); chk("pc_inc1", bus.pc_out, 16'hFFFF);
    tick(); chk("pc_wrap", bus.pc_out, 16'h0000);
    tick(); chk("pc_inc3", bus.pc_out, 16'h0001);
    idle(1'b0, 4'd15, 4'd0, 4'd1);
    tick(); chk("pc_hold", bus.pc_out, 16'h0001);

    // Branch with link.
    drive(1'b0, 1'b1, 4'd15, 16'h0040, 1'b1, 4'd14, 16'h0010, 1'b1, 4'd14, 4'd15, 4'd0);
    tick();
    idle(1'b0, 4'd14, 4'd15, 4'd0);
    #1;
    chk("br_pc",  bus.pc_out,    16'h0040);
    chk("br_lr",  bus.rd_data_a, 16'h0010);
    chk("br_col", {15'd0, bus.wr_collide}, 16'h0000);

    // Same-destination collision.
    drive(1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555, 1'b0, 4'd5, 4'd14, 4'd15);
    tick();
    idle(1'b0, 4'd5, 4'd14, 4'd15);
    #1;
    chk("col_r5",  bus.rd_data_a, 16'hAAAA);
    chk("col_set", {15'd0, bus.wr_collide}, 16'h0001);
    tick();
    chk("col_clr", {15'd0, bus.wr_collide}, 16'h0000);

    // Load with base writeback.
    drive(1'b0, 1'b1, 4'd2, 16'h00BE, 1'b1, 4'd7, 16'h0104, 1'b0, 4'd2, 4'd7, 4'd5);
    tick();
    idle(1'b0, 4'd2, 4'd7, 4'd5);
    #1;
    chk("ld_r2", bus.rd_data_a, 16'h00BE);
    chk("ld_r7", bus.rd_data_b, 16'h0104);
    chk("ld_r5", bus.rd_data_c, 16'hAAAA);

    // Same-cycle read of a register being written.
    drive(1'b0, 1'b1, 4'd4, 16'hC0DE, 1'b0, 4'd0, 16'h0, 1'b0, 4'd2, 4'd7, 4'd4);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", bus.rd_data_c, 16'hC0DE);
`else
    chk("byp_same", bus.rd_data_c, 16'h0000);
`endif
    tick();
    idle(1'b0, 4'd2, 4'd7, 4'd4);
    #1;
    chk("byp_next", bus.rd_data_c, 16'hC0DE);

    // Port 2 alone into R15, then disabled ports carrying X.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd15, 16'h0200, 1'b1, 4'd15, 4'd4, 4'd2);
    tick();
    drive(1'b0, 1'b0, 4'bxxxx, 16'hxxxx, 1'b0, 4'bxxxx, 16'hxxxx, 1'b1, 4'd15, 4'd4, 4'd2);
    #1;
    chk("wr2_pc", bus.pc_out, 16'h0200);
    tick();
    chk("x_ign_pc", bus.pc_out,    16'h0201);
    chk("x_ign_r4", bus.rd_data_b, 16'hC0DE);

    // Reset mid-operation overrides a concurrent write.
    drive(1'b1, 1'b1, 4'd2, 16'hFFFF, 1'b1, 4'd15, 16'h0777, 1'b1, 4'd2, 4'd15, 4'd4);
    tick();
    idle(1'b0, 4'd2, 4'd15, 4'd4);
    #1;
    chk("mid_rst_r2", bus.rd_data_a, 16'h0000);
    chk("mid_rst_pc", bus.pc_out,    PC_RESET);
    chk("mid_rst_r4", bus.rd_data_c, 16'h0000);

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    idle(1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    tick();

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
